// File: rtl/hwpe_stream_tcdm_fifo_store_sidech.sv
// Store-side TCDM decoupler: request FIFO, outstanding-store tracking, in-order sidechannel return; err_o via HWPE_STREAM_TCDM_STORE_ERR_EN.
// Latency: >=1 cycle slv->mst (no fall-through). Backpressure: slv_gnt_o=!full; issue stalls at MAX_OUTSTANDING.
module hwpe_stream_tcdm_fifo_store_sidech #(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned SIDECH_WIDTH    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   output logic                    flags_empty_o,
   input  logic                    slv_req_i,
   output logic                    slv_gnt_o,
   input  logic [31:0]             slv_add_i,
   input  logic                    slv_wen_i,
   input  logic [3:0]              slv_be_i,
   input  logic [31:0]             slv_data_i,
   input  logic [SIDECH_WIDTH-1:0] sidech_i,
   output logic                    mst_req_o,
   input  logic                    mst_gnt_i,
   output logic [31:0]             mst_add_o,
   output logic                    mst_wen_o,
   output logic [3:0]              mst_be_o,
   output logic [31:0]             mst_data_o,
   input  logic                    mst_r_valid_i,
   output logic [SIDECH_WIDTH-1:0] sidech_o,
   output logic                    sidech_valid_o
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
   ,
   output logic                    err_o
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [31:0]             add;
      logic [3:0]              be;
      logic [31:0]             data;
      logic [SIDECH_WIDTH-1:0] sidech;
   } entry_t;

   entry_t                  fifo_mem [FIFO_DEPTH];
   logic [AW:0]             wr_ptr;
   logic [AW:0]             rd_ptr;
   entry_t                  head;
   entry_t                  wr_entry;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic [SIDECH_WIDTH-1:0] trk_mem [MAX_OUTSTANDING];
   logic [TW-1:0]           trk_wr;
   logic [TW-1:0]           trk_rd;
   logic [CW-1:0]           outstanding;
   logic                    resp_ok;

   function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] idx);
      return (idx == TW'(MAX_OUTSTANDING - 1)) ? '0 : idx + TW'(1);
   endfunction

   assign flush      = rst_i | clear_i;
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign slv_gnt_o  = !fifo_full;

`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
   // A load request is granted so the streamer does not hang, but never stored.
   assign push = slv_req_i & slv_gnt_o & ~slv_wen_i;
`else
   logic unused_wen;
   assign unused_wen = slv_wen_i;
   assign push = slv_req_i & slv_gnt_o;
`endif

   assign wr_entry.add    = slv_add_i;
   assign wr_entry.be     = slv_be_i;
   assign wr_entry.data   = slv_data_i;
   assign wr_entry.sidech = sidech_i;

   assign head       = fifo_mem[rd_ptr[AW-1:0]];
   assign mst_req_o  = !fifo_empty && (outstanding < CW'(MAX_OUTSTANDING));
   assign pop        = mst_req_o & mst_gnt_i;
   assign mst_wen_o  = 1'b0;
   assign mst_add_o  = fifo_empty ? '0 : head.add;
   assign mst_be_o   = fifo_empty ? '0 : head.be;
   assign mst_data_o = fifo_empty ? '0 : head.data;

   assign resp_ok        = mst_r_valid_i && (outstanding != '0);
   assign sidech_valid_o = resp_ok;
   assign sidech_o       = (outstanding != '0) ? trk_mem[trk_rd] : '0;
   assign flags_empty_o  = fifo_empty && (outstanding == '0);

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= wr_entry;
      if (pop)  trk_mem[trk_wr] <= head.sidech;
   end

   // Tracking-queue occupancy always equals the outstanding count.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         trk_wr      <= '0;
         trk_rd      <= '0;
         outstanding <= '0;
      end else begin
         if (pop)     trk_wr <= trk_next(trk_wr);
         if (resp_ok) trk_rd <= trk_next(trk_rd);
         if (pop && !resp_ok)      outstanding <= outstanding + CW'(1);
         else if (!pop && resp_ok) outstanding <= outstanding - CW'(1);
      end
   end

`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
   always_ff @(posedge clk_i) begin
      if (flush) begin
         err_o <= 1'b0;
      end else if ((mst_r_valid_i && (outstanding == '0)) || (slv_req_i && slv_wen_i)) begin
         err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store_sidech.sv
// Directed bench for hwpe_stream_tcdm_fifo_store_sidech (FIFO_DEPTH=8, MAX_OUTSTANDING=4, SIDECH_WIDTH=1).
module tb_hwpe_stream_tcdm_fifo_store_sidech;

   logic        clk_i = 1'b0;
   logic        rst_i, clear_i, flags_empty_o;
   logic        slv_req_i, slv_gnt_o, slv_wen_i;
   logic [31:0] slv_add_i, slv_data_i;
   logic [3:0]  slv_be_i;
   logic [0:0]  sidech_i, sidech_o;
   logic        mst_req_o, mst_gnt_i, mst_wen_o, mst_r_valid_i, sidech_valid_o;
   logic [31:0] mst_add_o, mst_data_o;
   logic [3:0]  mst_be_o;
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
   logic        err_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   hwpe_stream_tcdm_fifo_store_sidech #(
      .FIFO_DEPTH(8), .MAX_OUTSTANDING(4), .SIDECH_WIDTH(1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .flags_empty_o(flags_empty_o),
      .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
      .slv_be_i(slv_be_i), .slv_data_i(slv_data_i), .sidech_i(sidech_i),
      .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o),
      .mst_be_o(mst_be_o), .mst_data_o(mst_data_o), .mst_r_valid_i(mst_r_valid_i),
      .sidech_o(sidech_o), .sidech_valid_o(sidech_valid_o)
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
      , .err_o(err_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      rst_i = 1'b0; clear_i = 1'b0; slv_req_i = 1'b0; slv_wen_i = 1'b0;
      slv_add_i = '0; slv_data_i = '0; slv_be_i = '0; sidech_i = '0;
      mst_gnt_i = 1'b0; mst_r_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      slv_req_i = 1'b1; slv_add_i = 32'h40; slv_data_i = 32'h1234; slv_be_i = 4'h3; sidech_i = 1'b1;
      tick();
      tick();
      slv_req_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b0) begin n_bad++; $display("FAIL reset_pre_empty: got %0h expected 0", flags_empty_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      n_cmp++; if (slv_gnt_o !== 1'b1) begin n_bad++; $display("FAIL reset_gnt: got %0h expected 1", slv_gnt_o); end
      n_cmp++; if (mst_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0h expected 0", mst_req_o); end
      n_cmp++; if (sidech_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_sidech_valid: got %0h expected 0", sidech_valid_o); end
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0h expected 1", flags_empty_o); end
      n_cmp++; if (mst_add_o !== 32'h0) begin n_bad++; $display("FAIL reset_add: got %0h expected 0", mst_add_o); end
      n_cmp++; if (mst_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", mst_data_o); end
      n_cmp++; if (mst_be_o !== 4'h0) begin n_bad++; $display("FAIL reset_be: got %0h expected 0", mst_be_o); end
      n_cmp++; if (sidech_o !== 1'b0) begin n_bad++; $display("FAIL reset_sidech: got %0h expected 0", sidech_o); end
      n_cmp++; if (mst_wen_o !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %0h expected 0", mst_wen_o); end
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0h expected 0", err_o); end
`endif
   endtask

   task automatic test_single();
      do_reset();
      slv_req_i = 1'b1; slv_add_i = 32'h100; slv_data_i = 32'hDEADBEEF; slv_be_i = 4'hF; sidech_i = 1'b1;
      mst_gnt_i = 1'b1;
      #1;
      n_cmp++; if (slv_gnt_o !== 1'b1) begin n_bad++; $display("FAIL single_gnt: got %0h expected 1", slv_gnt_o); end
      n_cmp++; if (mst_req_o !== 1'b0) begin n_bad++; $display("FAIL single_no_fallthrough: got %0h expected 0", mst_req_o); end
      tick();
      slv_req_i = 1'b0;
      #1;
      n_cmp++; if (mst_req_o !== 1'b1) begin n_bad++; $display("FAIL single_req: got %0h expected 1", mst_req_o); end
      n_cmp++; if (mst_add_o !== 32'h100) begin n_bad++; $display("FAIL single_add: got %0h expected 100", mst_add_o); end
      n_cmp++; if (mst_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %0h expected deadbeef", mst_data_o); end
      n_cmp++; if (mst_be_o !== 4'hF) begin n_bad++; $display("FAIL single_be: got %0h expected f", mst_be_o); end
      tick();
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_sidech_valid: got %0h expected 1", sidech_valid_o); end
      n_cmp++; if (sidech_o !== 1'b1) begin n_bad++; $display("FAIL single_sidech: got %0h expected 1", sidech_o); end
      n_cmp++; if (flags_empty_o !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %0h expected 0", flags_empty_o); end
      tick();
      mst_r_valid_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL single_drained: got %0h expected 1", flags_empty_o); end
      n_cmp++; if (sidech_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_pulse_end: got %0h expected 0", sidech_valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea, ed;
      logic [3:0]  eb;
      logic        es;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         slv_req_i = 1'b1; slv_add_i = 32'h200 + 4 * i; slv_data_i = 32'hA0000000 + i;
         slv_be_i = 4'(i + 1); sidech_i = 1'(i % 2);
         #1;
         n_cmp++; if (slv_gnt_o !== 1'b1) begin n_bad++; $display("FAIL fill_gnt[%0d]: got %0h expected 1", i, slv_gnt_o); end
         tick();
      end
      // FIFO full: this attempt must not be stored.
      slv_req_i = 1'b1; slv_add_i = 32'hBAD; slv_data_i = 32'hBAD;
      #1;
      n_cmp++; if (slv_gnt_o !== 1'b0) begin n_bad++; $display("FAIL full_gnt: got %0h expected 0", slv_gnt_o); end
      n_cmp++; if (mst_add_o !== 32'h200) begin n_bad++; $display("FAIL stall_head: got %0h expected 200", mst_add_o); end
      tick();
      slv_req_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mst_gnt_i = 1'b1;
         mst_r_valid_i = (i > 0);
         ea = 32'h200 + 4 * i; ed = 32'hA0000000 + i; eb = 4'(i + 1); es = 1'((i - 1) % 2);
         #1;
         n_cmp++; if (mst_req_o !== 1'b1) begin n_bad++; $display("FAIL drain_req[%0d]: got %0h expected 1", i, mst_req_o); end
         n_cmp++; if (mst_add_o !== ea) begin n_bad++; $display("FAIL drain_add[%0d]: got %0h expected %0h", i, mst_add_o, ea); end
         n_cmp++; if (mst_data_o !== ed) begin n_bad++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, mst_data_o, ed); end
         n_cmp++; if (mst_be_o !== eb) begin n_bad++; $display("FAIL drain_be[%0d]: got %0h expected %0h", i, mst_be_o, eb); end
         if (i > 0) begin
            n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== es) begin n_bad++; $display("FAIL drain_sidech[%0d]: got v=%0h s=%0h expected v=1 s=%0h", i, sidech_valid_o, sidech_o, es); end
         end
         tick();
      end
      mst_gnt_i = 1'b0; mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (mst_req_o !== 1'b0) begin n_bad++; $display("FAIL drain_extra_req: got %0h expected 0", mst_req_o); end
      n_cmp++; if (sidech_o !== 1'b1) begin n_bad++; $display("FAIL drain_last_sidech: got %0h expected 1", sidech_o); end
      tick();
      mst_r_valid_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %0h expected 1", flags_empty_o); end
   endtask

   task automatic test_outstanding_limit();
      int ng;
      do_reset();
      mst_gnt_i = 1'b1;
      ng = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < 6) begin
            slv_req_i = 1'b1; slv_add_i = 32'h300 + c; slv_data_i = c; slv_be_i = 4'hF; sidech_i = 1'(c % 2);
         end else begin
            slv_req_i = 1'b0;
         end
         #1;
         if (mst_req_o && mst_gnt_i) ng++;
         tick();
      end
      #1;
      n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL limit_grants: got %0d expected 4", ng); end
      n_cmp++; if (mst_req_o !== 1'b0) begin n_bad++; $display("FAIL limit_req: got %0h expected 0", mst_req_o); end
      n_cmp++; if (flags_empty_o !== 1'b0) begin n_bad++; $display("FAIL limit_empty: got %0h expected 0", flags_empty_o); end
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (mst_req_o !== 1'b0) begin n_bad++; $display("FAIL limit_req_on_resp: got %0h expected 0", mst_req_o); end
      n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== 1'b0) begin n_bad++; $display("FAIL limit_resp: got v=%0h s=%0h expected v=1 s=0", sidech_valid_o, sidech_o); end
      tick();
      mst_r_valid_i = 1'b0;
      ng = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (mst_req_o && mst_gnt_i) ng++;
         tick();
      end
      n_cmp++; if (ng !== 1) begin n_bad++; $display("FAIL limit_resume: got %0d expected 1", ng); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         slv_req_i = 1'b1; slv_add_i = 32'h400 + k; slv_data_i = k; slv_be_i = 4'h1; sidech_i = 1'(k != 1);
         tick();
      end
      slv_req_i = 1'b0; mst_gnt_i = 1'b1;
      tick();
      tick();
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (mst_req_o !== 1'b1) begin n_bad++; $display("FAIL same_req: got %0h expected 1", mst_req_o); end
      n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== 1'b1) begin n_bad++; $display("FAIL same_oldest: got v=%0h s=%0h expected v=1 s=1", sidech_valid_o, sidech_o); end
      tick();
      mst_gnt_i = 1'b0;
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== 1'b0) begin n_bad++; $display("FAIL same_second: got v=%0h s=%0h expected v=1 s=0", sidech_valid_o, sidech_o); end
      tick();
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== 1'b1) begin n_bad++; $display("FAIL same_third: got v=%0h s=%0h expected v=1 s=1", sidech_valid_o, sidech_o); end
      tick();
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b0) begin n_bad++; $display("FAIL same_count_two: got %0h expected 0", sidech_valid_o); end
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL same_empty: got %0h expected 1", flags_empty_o); end
      tick();
      mst_r_valid_i = 1'b0;
   endtask

   task automatic test_clear();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         slv_req_i = 1'b1; slv_add_i = 32'h600 + k; slv_data_i = k; slv_be_i = 4'h2; sidech_i = 1'b1;
         tick();
      end
      slv_req_i = 1'b0; mst_gnt_i = 1'b1;
      tick();
      tick();
      mst_gnt_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b0 || mst_add_o !== 32'h602) begin n_bad++; $display("FAIL clear_pre: got empty=%0h add=%0h expected empty=0 add=602", flags_empty_o, mst_add_o); end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL clear_empty: got %0h expected 1", flags_empty_o); end
      n_cmp++; if (slv_gnt_o !== 1'b1) begin n_bad++; $display("FAIL clear_gnt: got %0h expected 1", slv_gnt_o); end
      n_cmp++; if (mst_req_o !== 1'b0 || mst_add_o !== 32'h0) begin n_bad++; $display("FAIL clear_mst: got req=%0h add=%0h expected req=0 add=0", mst_req_o, mst_add_o); end
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_late_resp: got %0h expected 0", sidech_valid_o); end
      tick();
      mst_r_valid_i = 1'b0;
      #1;
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL clear_err: got %0h expected 1", err_o); end
`endif
   endtask

   task automatic test_spurious();
      do_reset();
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b0 || sidech_o !== 1'b0) begin n_bad++; $display("FAIL spur_resp: got v=%0h s=%0h expected v=0 s=0", sidech_valid_o, sidech_o); end
      tick();
      mst_r_valid_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL spur_no_underflow: got %0h expected 1", flags_empty_o); end
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL spur_err: got %0h expected 1", err_o); end
`endif
      slv_req_i = 1'b1; slv_add_i = 32'h500; slv_data_i = 32'h55; slv_be_i = 4'hC; sidech_i = 1'b1; mst_gnt_i = 1'b1;
      tick();
      slv_req_i = 1'b0;
      #1;
      n_cmp++; if (mst_req_o !== 1'b1) begin n_bad++; $display("FAIL spur_issue: got %0h expected 1", mst_req_o); end
      tick();
      mst_r_valid_i = 1'b1;
      #1;
      n_cmp++; if (sidech_valid_o !== 1'b1 || sidech_o !== 1'b1) begin n_bad++; $display("FAIL spur_real_resp: got v=%0h s=%0h expected v=1 s=1", sidech_valid_o, sidech_o); end
      tick();
      mst_r_valid_i = 1'b0; mst_gnt_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL spur_final_empty: got %0h expected 1", flags_empty_o); end
   endtask

`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
   task automatic test_wen_err();
      do_reset();
      slv_req_i = 1'b1; slv_wen_i = 1'b1; slv_add_i = 32'h700;
      #1;
      n_cmp++; if (slv_gnt_o !== 1'b1) begin n_bad++; $display("FAIL wen_gnt: got %0h expected 1", slv_gnt_o); end
      tick();
      slv_req_i = 1'b0; slv_wen_i = 1'b0;
      #1;
      n_cmp++; if (flags_empty_o !== 1'b1) begin n_bad++; $display("FAIL wen_not_stored: got %0h expected 1", flags_empty_o); end
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL wen_err: got %0h expected 1", err_o); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_outstanding_limit();
      test_same_cycle();
      test_clear();
      test_spurious();
`ifdef HWPE_STREAM_TCDM_STORE_ERR_EN
      test_wen_err();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hwpe_stream_tcdm_fifo_store_sidech.md
Name: hwpe_stream_tcdm_fifo_store_sidech

Overview:
Store-direction decoupling block between a streamer's TCDM store port and the TCDM interconnect; the write-side counterpart of the load FIFO.
- Accepts store requests (address, data, byte enables, sidechannel) into a request FIFO and replays them towards the interconnect.
- Tracks outstanding stores until their write responses return.
- Returns the sidechannel of each acknowledged store, in order, so the streamer can count completed writes.
- The empty flag reports true only when the block is fully drained.

Parameters:
FIFO_DEPTH, 8, request FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max stores granted by the interconnect and not yet acknowledged (>=1)
SIDECH_WIDTH, 1, sidechannel bits carried per store

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
clear_i  in  1  synchronous soft clear, same effect as rst_i
flags_empty_o  out  1  request FIFO empty AND outstanding count == 0
slv_req_i  in  1  upstream store request
slv_gnt_o  out  1  upstream grant
slv_add_i  in  32  store address
slv_wen_i  in  1  must be 0 (store); ignored internally
slv_be_i  in  4  byte enables
slv_data_i  in  32  store data
sidech_i  in  SIDECH_WIDTH  sidechannel captured with the request
mst_req_o  out  1  TCDM request
mst_gnt_i  in  1  TCDM grant
mst_add_o  out  32  TCDM address
mst_wen_o  out  1  constant 0
mst_be_o  out  4  TCDM byte enables
mst_data_o  out  32  TCDM write data
mst_r_valid_i  in  1  TCDM write response, in order
sidech_o  out  SIDECH_WIDTH  sidechannel of the acknowledged store
sidech_valid_o  out  1  one-cycle pulse per acknowledged store

Behaviour:
Reset and clear:
- rst_i or clear_i empties the request FIFO and tracking queue and zeroes the outstanding counter.
- Values after reset/clear: slv_gnt_o=1, mst_req_o=0, sidech_valid_o=0, flags_empty_o=1.
- mst_add_o, mst_be_o and mst_data_o output 0 while the FIFO is empty.
- A clear asserted mid-operation drops all state. Responses for stores granted before the clear are then treated as spurious.

Request FIFO:
- Entry = {add, be, data, sidech}.
- slv_gnt_o = !full. There is no write-through when full: a same-cycle pop does not raise the grant.
- Push when slv_req_i & slv_gnt_o.
- No fall-through: an entry pushed in cycle t is presented on mst_* in cycle t+1 at the earliest.

Master side:
- mst_req_o = !fifo_empty & (outstanding < MAX_OUTSTANDING).
- mst_add_o, mst_be_o, mst_data_o = FIFO head.
- Pop when mst_req_o & mst_gnt_i.
- The head stays stable while mst_req_o=1 and mst_gnt_i=0.

Tracking queue and outstanding counter:
- Tracking queue: depth MAX_OUTSTANDING, width SIDECH_WIDTH. The head sidech is pushed on each pop.
- Outstanding counter: width $clog2(MAX_OUTSTANDING+1).
  - +1 on pop.
  - -1 on accepted response.
  - Unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING.

Response:
- Accepted response = mst_r_valid_i & (outstanding != 0).
- sidech_valid_o = accepted response, combinational, same cycle as mst_r_valid_i.
- sidech_o = tracking queue head; it pops in the same cycle.
- sidech_o outputs 0 when the tracking queue is empty.
- A response with outstanding == 0 is spurious: it is ignored and the counter does not underflow.

Boundaries:
- Simultaneous push and pop with the FIFO non-full and non-empty: occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Outstanding == MAX_OUTSTANDING with a response in the same cycle: mst_req_o stays 0 in that cycle (evaluated on the registered count). Issue resumes in the next cycle.

Optional Feature:
Macro HWPE_STREAM_TCDM_STORE_ERR_EN.
- Defined: extra port err_o (out, 1), a sticky flag.
  - Set in the cycle after a spurious response, or after any push attempt with slv_req_i & !slv_wen_i == 0, i.e. slv_wen_i=1.
  - Cleared only by rst_i or clear_i.
  - In the load case the offending request is still granted but not stored.
- Undefined: no err_o port; spurious responses are silently ignored; slv_wen_i is fully ignored.

Test Plan:
- Single store (add=0x100, data=0xDEADBEEF, be=0xF, sidech=1), mst_gnt_i=1, response one cycle after grant -> mst_req_o=1 in cycle t+1, sidech_valid_o pulse with sidech_o=1 in t+2, flags_empty_o=1 in t+3.
- mst_gnt_i=0 with 8 back-to-back pushes (FIFO_DEPTH=8) -> slv_gnt_o=0 after the 8th push. Release the grant -> 8 stores issue in push order with matching add/data/be.
- mst_gnt_i=1, no responses -> exactly 4 grants, mst_req_o=0 while outstanding=4. One response -> exactly one further issue.
- Same-cycle pop and response with outstanding=2 -> count stays 2, sidech_o matches the oldest store.
- clear_i pulse with 3 entries queued and 2 outstanding -> next cycle flags_empty_o=1, slv_gnt_o=1. Late response -> no sidech_valid_o; err_o=1 if macro defined.
- Spurious mst_r_valid_i after reset -> counter stays 0, sidech_valid_o=0; err_o=1 next cycle if macro defined.
